// File: rtl/frame_pkg.sv
// Shared definitions for the frame rate balancer and its trigger-block peer:
// FSM state encoding, default geometry and the word-counter width helper.
package frame_pkg;

  localparam int FRAME_SIZE_DEF = 1280;
  localparam int DATA_W_DEF     = 24;
  localparam int STATE_W        = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_PASS   = 3'd2,
    ST_DROP   = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

  function automatic int wcnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_out_stage.sv
// One-deep valid/ready output register carrying a word plus its sof/eof tags.
module frame_out_stage #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              sof_i,
  input  logic              eof_i,
  input  logic              ready_i,
  output logic              can_accept_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              sof_o,
  output logic              eof_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              sof_q,   sof_d;
  logic              eof_q,   eof_d;

  // A new word may enter when the slot is free or being drained this cycle.
  assign can_accept_o = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sof_d   = sof_q;
    eof_d   = eof_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      sof_d   = sof_i;
      eof_d   = eof_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sof_o   = sof_q;
  assign eof_o   = eof_q;

endmodule

// File: rtl/frame_rate_balancer.sv
// Pops whole frames from the FWFT frame FIFO and passes, drops or holds them
// at each frame boundary according to the trigger block's level flags.
module frame_rate_balancer
  import frame_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FRAME_SIZE = FRAME_SIZE_DEF,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_i,
  input  logic [DATA_W-1:0] fifo_dout_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_en_o,
  input  logic              trigger_FIFO_full_i,
  input  logic              trigger_FIFO_empty_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              m_sof_o,
  output logic              m_eof_o,
  output logic [CNT_W-1:0]  frames_dropped_o,
  output logic [CNT_W-1:0]  holds_o,
  output logic [2:0]        state_o
);

  localparam int                WCNT_W   = wcnt_w(FRAME_SIZE);
  localparam logic [WCNT_W-1:0] LAST_IDX = WCNT_W'(FRAME_SIZE - 1);

  state_e             state_q, state_d;
  logic [WCNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]   drops_q, drops_d;
  logic [CNT_W-1:0]   holds_q, holds_d;
  logic               can_accept;
  logic               pop;
  logic               load;
  logic               last_word;

  assign last_word = (word_cnt_q == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (enable_i) state_d = ST_SELECT;
      ST_SELECT: begin
        if      (!enable_i)            state_d = ST_IDLE;
        else if (trigger_FIFO_full_i)  state_d = ST_DROP;
        else if (trigger_FIFO_empty_i) state_d = ST_HOLD;
        else                           state_d = ST_PASS;
      end
      ST_PASS, ST_DROP: if (pop && last_word) state_d = ST_SELECT;
      // A rising full flag also leaves HOLD so SELECT can turn it into a drop.
      ST_HOLD:   if (!trigger_FIFO_empty_i || trigger_FIFO_full_i) state_d = ST_SELECT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pop  = 1'b0;
    load = 1'b0;
    case (state_q)
      ST_PASS: begin
        pop  = !fifo_empty_i && can_accept;
        load = pop;
      end
      ST_DROP: pop = !fifo_empty_i;
      default: ;
    endcase
  end

  always_comb begin
    word_cnt_d = word_cnt_q;
    drops_d    = drops_q;
    holds_d    = holds_q;
    if (pop) word_cnt_d = last_word ? '0 : word_cnt_q + 1'b1;
    if (state_q == ST_SELECT && enable_i) begin
      if (trigger_FIFO_full_i) begin
        if (drops_q != '1) drops_d = drops_q + 1'b1;
      end else if (trigger_FIFO_empty_i) begin
        if (holds_q != '1) holds_d = holds_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_cnt_q <= '0;
      drops_q    <= '0;
      holds_q    <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      drops_q    <= drops_d;
      holds_q    <= holds_d;
    end
  end

  frame_out_stage #(.DATA_W(DATA_W)) u_out (
    .clk          (clk),
    .reset        (reset),
    .load_i       (load),
    .data_i       (fifo_dout_i),
    .sof_i        (word_cnt_q == '0),
    .eof_i        (last_word),
    .ready_i      (m_ready_i),
    .can_accept_o (can_accept),
    .valid_o      (m_valid_o),
    .data_o       (m_data_o),
    .sof_o        (m_sof_o),
    .eof_o        (m_eof_o)
  );

  assign fifo_rd_en_o     = pop;
  assign frames_dropped_o = drops_q;
  assign holds_o          = holds_q;
  assign state_o          = state_q;

endmodule

// File: doc/frame_rate_balancer.md
Name: frame_rate_balancer

Overview:
- Downstream consumer of the frame-FIFO trigger flags (trigger_FIFO_full / trigger_FIFO_empty) and of the FIFO read port.
- Pops whole frames from the first-word-fall-through frame FIFO and forwards them to the display/sink over a valid/ready stream.
- At each frame boundary it chooses one of three actions: pass the next frame, drop it when the FIFO is above its upper bound, or hold when the FIFO is below its lower bound.
- It drives the fifo_rd_en that the trigger block observes, so the two blocks close the rate-balancing loop.

Parameters:
- DATA_W, 24: FIFO word / pixel width.
- FRAME_SIZE, 1280: words per frame; must match the trigger block's frame_size.
- CNT_W, 16: width of the saturating status counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- enable_i  in  1  run request; sampled only at frame boundaries.
- fifo_dout_i  in  DATA_W  FWFT head word.
- fifo_empty_i  in  1  FIFO empty.
- fifo_rd_en_o  out  1  pop the head word.
- trigger_FIFO_full_i  in  1  upper-bound flag from the trigger block.
- trigger_FIFO_empty_i  in  1  lower-bound flag from the trigger block.
- m_data_o  out  DATA_W  output word.
- m_valid_o  out  1  output word valid.
- m_ready_i  in  1  sink accepts the word.
- m_sof_o  out  1  first word of the frame; qualified by m_valid_o.
- m_eof_o  out  1  last word of the frame; qualified by m_valid_o.
- frames_dropped_o  out  CNT_W  saturating count of dropped frames.
- holds_o  out  CNT_W  saturating count of hold episodes.
- state_o  out  3  current FSM state encoding, for debug.

Behaviour:
- Reset (async, active-low): state=IDLE, word_cnt=0.
  - All outputs 0: fifo_rd_en_o, m_valid_o, m_sof_o, m_eof_o, m_data_o, both counters.
  - A reset mid-frame abandons the frame. The FIFO is flushed by its owner, not by this block.
- word_cnt: $clog2(FRAME_SIZE) bits. Increments on every pop in PASS or DROP. When it reaches FRAME_SIZE-1 and a pop occurs, it wraps to 0 and that pop is the frame's last word.
- FSM states: IDLE, SELECT, PASS, DROP, HOLD.
  - IDLE: go to SELECT when enable_i=1.
  - SELECT (exactly 1 cycle, no pop). Priority order:
    - enable_i=0 -> IDLE.
    - else trigger_FIFO_full_i=1 -> DROP; frames_dropped_o increments.
    - else trigger_FIFO_empty_i=1 -> HOLD; holds_o increments.
    - else -> PASS.
  - SELECT sits one cycle after the last pop, so it sees the trigger flags already updated by that pop.
  - PASS:
    - fifo_rd_en_o = !fifo_empty_i && (!m_valid_o || m_ready_i), combinational.
    - The popped word is registered into m_data_o / m_valid_o on the next edge (1-cycle latency).
    - m_sof_o is registered with word_cnt==0; m_eof_o is registered with word_cnt==FRAME_SIZE-1.
    - The pop of the last word moves the FSM to SELECT.
  - DROP:
    - fifo_rd_en_o = !fifo_empty_i; the output register is not loaded.
    - After FRAME_SIZE pops -> SELECT.
    - Exactly one frame is dropped per SELECT decision.
  - HOLD: no pops. Return to SELECT once trigger_FIFO_empty_i=0. A full flag rising during HOLD is also handled through SELECT.
- Output register:
  - m_valid_o clears when m_ready_i=1 and no new word is loaded.
  - Data stays stable while m_valid_o=1 and m_ready_i=0.
  - Sustains 1 word/clk when the sink is always ready.
- Invariant: fifo_rd_en_o is never asserted while fifo_empty_i=1, in any state.
- enable_i deasserted mid-frame has no effect until the frame completes. The pending output word still drains in IDLE.
- Counters saturate at all-ones; they never wrap.
- FIFO running dry mid-frame stalls with word_cnt held. The frame resumes when data returns; it is never truncated.

Decomposition:
- Shared package `frame_pkg`:
  - state enum and 3-bit encoding;
  - FRAME_SIZE default (shared with the trigger block) and DATA_W default;
  - word-count width function.
- One natural sub-module, `frame_out_stage`: the 1-deep valid/ready output register carrying data, sof and eof, with a load input and a can_accept output.

Test Plan (FRAME_SIZE=16 override, DATA_W=8, data = incrementing words):
- Steady state: both flags 0, enable=1, FIFO preloaded with 48 words, m_ready=1 -> 48 words out in order. m_sof on words 0/16/32, m_eof on 15/31/47. One bubble per frame (SELECT). Counters stay 0.
- Drop: trigger_FIFO_full_i=1 during the second SELECT -> words 16..31 popped but never output. frames_dropped_o=1. Output resumes at 32 with m_sof=1.
- Hold: trigger_FIFO_empty_i=1 at SELECT for 10 cycles -> no pops for 10 cycles, holds_o=1. On release, SELECT then PASS.
- Simultaneous flags at SELECT -> DROP chosen; holds_o unchanged.
- Backpressure: m_ready_i toggles 1/0 every cycle, and the FIFO goes empty for 5 cycles mid-frame -> m_data_o stable while stalled, no pop while empty, word order intact, eof on the 16th word.
- Reset mid-frame (after 7 words): all outputs 0 immediately. After release with enable=1 and a flushed and refilled FIFO, the first output word carries m_sof=1.
